// File: rtl/ifu_if.sv
// Instruction memory fetch channel between the IFU and instruction memory.
// The IFU holds imem_req for the whole fetch; imem_ack marks imem_rdata valid.
interface ifu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack channel and
// holds the decoded instruction fields until the datapath retires it.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_if.master       imem,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  input  logic        exec_done,
  input  logic        nPC_sel,
  input  logic        zero,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] ir_q;
  logic [31:0] ir_d;
  logic [31:0] ret_q;
  logic [31:0] ret_d;

  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] br_pc;
  logic        taken;

  assign seq_pc = pc_q + 32'd4;
  assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign br_pc  = seq_pc + br_off;
  assign taken  = nPC_sel & zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
    end
  end

  // Handshake inputs only matter in their own state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          pc_d    = taken ? br_pc : seq_pc;
          ret_d   = ret_q + 32'd1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == ISSUE);

  assign opcode  = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign funct   = ir_q[5:0];
  assign imm16   = ir_q[15:0];
  assign pc      = pc_q;
  assign retired = ret_q;

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: expected fetch addresses and issued words are
// queued as stimulus is driven and checked when the DUT presents them.
module tb_ifu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ifu_if imem ();
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic        exec_done;
  logic        nPC_sel;
  logic        zero;
  logic [31:0] retired;

  ifu u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .funct       (funct),
    .imm16       (imm16),
    .pc          (pc),
    .exec_done   (exec_done),
    .nPC_sel     (nPC_sel),
    .zero        (zero),
    .retired     (retired)
  );

  ifu_if wimem ();
  logic        w_valid;
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [15:0] w_imm16;
  logic [31:0] w_pc;
  logic        w_done;
  logic [31:0] w_retired;

  ifu #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (wimem),
    .instr_valid (w_valid),
    .opcode      (w_opcode),
    .rs          (w_rs),
    .rt          (w_rt),
    .rd          (w_rd),
    .funct       (w_funct),
    .imm16       (w_imm16),
    .pc          (w_pc),
    .exec_done   (w_done),
    .nPC_sel     (1'b0),
    .zero        (1'b0),
    .retired     (w_retired)
  );

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  logic [31:0] word_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_fields(input string tag, input logic [31:0] w);
    check({tag, "_op"}, {26'd0, opcode}, {26'd0, w[31:26]});
    check({tag, "_rs"}, {27'd0, rs}, {27'd0, w[25:21]});
    check({tag, "_rt"}, {27'd0, rt}, {27'd0, w[20:16]});
    check({tag, "_rd"}, {27'd0, rd}, {27'd0, w[15:11]});
    check({tag, "_fn"}, {26'd0, funct}, {26'd0, w[5:0]});
    check({tag, "_imm"}, {16'd0, imm16}, {16'd0, w[15:0]});
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem.imem_req) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] word, input int dly,
                       output int t0);
    logic [31:0] e;
    logic [31:0] a0;
    bit ok;
    wait_req(ok);
    t0 = cyc;
    if (!ok) return;
    if (exp_q.size() == 0) begin
      check("addr_q_empty", 32'd0, 32'd1);
      e = 32'hx;
    end else begin
      e = exp_q.pop_front();
    end
    check("imem_addr", imem.imem_addr, e);
    check("pc", pc, e);
    a0 = imem.imem_addr;
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      check("stall_req", {31'd0, imem.imem_req}, 32'd1);
      check("stall_addr", imem.imem_addr, a0);
      check("stall_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = word;
    word_q.push_back(word);
    @(posedge clk); #1;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = $urandom;
  endtask

  task automatic issue(input logic nsel, input logic z, input int dly);
    logic [31:0] w;
    logic [31:0] off;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      check("valid_timeout", 32'd0, 32'd1);
      return;
    end
    if (word_q.size() == 0) begin
      check("word_q_empty", 32'd0, 32'd1);
      return;
    end
    w = word_q.pop_front();
    check_fields("issue", w);
    for (int i = 0; i < dly; i++) begin
      nPC_sel         = 1'($urandom);
      zero            = 1'($urandom);
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = ~w;
      @(posedge clk); #1;
      check("hold_req", {31'd0, imem.imem_req}, 32'd0);
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check_fields("hold", w);
    end
    imem.imem_ack = 1'b0;
    nPC_sel   = nsel;
    zero      = z;
    exec_done = 1'b1;
    @(posedge clk); #1;
    exec_done = 1'b0;
    nPC_sel   = 1'($urandom);
    zero      = 1'($urandom);
    off   = {{14{w[15]}}, w[15:0], 2'b00};
    m_pc  = (nsel & z) ? m_pc + 32'd4 + off : m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
    exp_q.push_back(m_pc);
    check("retired", retired, m_ret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    int t2;
    int t3;
    int tx;
    bit ok;
    rst_n = 1'b0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = '0;
    exec_done = 1'b0;
    nPC_sel   = 1'b0;
    zero      = 1'b0;
    wimem.imem_ack   = 1'b0;
    wimem.imem_rdata = '0;
    w_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_req", {31'd0, imem.imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_addr", imem.imem_addr, 32'h3000);
    check("rst_pc", pc, 32'h3000);
    check("rst_retired", retired, 32'd0);
    check_fields("rst", 32'd0);
    check("rst_waddr", wimem.imem_addr, 32'hFFFF_FFFC);

    @(posedge clk); #1;
    check("first_req", {31'd0, imem.imem_req}, 32'd1);
    check("first_addr", imem.imem_addr, 32'h3000);

    m_pc  = 32'h3000;
    m_ret = 32'd0;
    exp_q.push_back(m_pc);

    fetch(32'h012A_4020, 0, t1);
    check("dec_op", {26'd0, opcode}, 32'd0);
    check("dec_rs", {27'd0, rs}, 32'd9);
    check("dec_rt", {27'd0, rt}, 32'd10);
    check("dec_rd", {27'd0, rd}, 32'd8);
    check("dec_fn", {26'd0, funct}, 32'h20);
    issue(1'b0, 1'b0, 0);
    fetch(32'h014B_4822, 0, t2);
    check("thru_1", t2 - t1, 32'd2);
    issue(1'b0, 1'b0, 0);
    fetch(32'h8D28_0004, 0, t3);
    check("thru_2", t3 - t2, 32'd2);
    issue(1'b0, 1'b0, 0);
    check("retired_3", retired, 32'd3);
    check("addr_300c", imem.imem_addr, 32'h300C);

    fetch(32'h0000_0000, 0, tx);
    issue(1'b1, 1'b0, 0);
    check("addr_3010", imem.imem_addr, 32'h3010);

    fetch(32'h1000_FFFF, 0, tx);
    issue(1'b1, 1'b1, 0);
    check("beq_back", imem.imem_addr, 32'h3010);

    fetch(32'h1000_FFFF, 3, tx);
    issue(1'b1, 1'b0, 4);
    check("beq_nt", imem.imem_addr, 32'h3014);

    fetch(32'h1000_0003, 0, tx);
    issue(1'b1, 1'b1, 0);
    check("beq_fwd", imem.imem_addr, 32'h3024);

    check("wrap_req", {31'd0, wimem.imem_req}, 32'd1);
    check("wrap_addr0", wimem.imem_addr, 32'hFFFF_FFFC);
    wimem.imem_ack   = 1'b1;
    wimem.imem_rdata = 32'h012A_4020;
    @(posedge clk); #1;
    wimem.imem_ack = 1'b0;
    check("wrap_valid", {31'd0, w_valid}, 32'd1);
    w_done = 1'b1;
    @(posedge clk); #1;
    w_done = 1'b0;
    check("wrap_addr", wimem.imem_addr, 32'h0000_0000);
    check("wrap_ret", w_retired, 32'd1);

    wait_req(ok);
    exp_q.delete();
    word_q.delete();
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    #2 rst_n = 1'b0;
    #1;
    check("mid_req", {31'd0, imem.imem_req}, 32'd0);
    check("mid_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_pc", pc, 32'h3000);
    check("mid_ret", retired, 32'd0);
    check_fields("mid", 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    imem.imem_ack = 1'b0;
    check("late_req", {31'd0, imem.imem_req}, 32'd1);
    check("late_addr", imem.imem_addr, 32'h3000);
    check("late_valid", {31'd0, instr_valid}, 32'd0);
    check_fields("late", 32'd0);

    m_pc  = 32'h3000;
    m_ret = 32'd0;
    exp_q.push_back(m_pc);
    fetch(32'h012A_4020, 1, tx);
    issue(1'b0, 1'b1, 2);
    check("post_addr", imem.imem_addr, 32'h3004);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
